// File: rtl/noc_pkg.sv
// Shared NoC router definitions: packet field layout, direction codes and
// default input-buffer sizing.
package noc_pkg;

  localparam int unsigned DATASIZE = 40;

  localparam int unsigned SRC_MSB  = 39;
  localparam int unsigned SRC_LSB  = 36;
  localparam int unsigned DST_MSB  = 35;
  localparam int unsigned DST_LSB  = 32;
  localparam int unsigned TS_MSB   = 31;
  localparam int unsigned TS_LSB   = 24;
  localparam int unsigned DATA_MSB = 23;
  localparam int unsigned DATA_LSB = 2;
  localparam int unsigned TYPE_MSB = 1;
  localparam int unsigned TYPE_LSB = 0;

  localparam int unsigned IB_DEPTH = 8;
  localparam int unsigned IB_WIDTH = 3;

  typedef enum logic [3:0] {
    DIR_LOCAL   = 4'b0000,
    DIR_W       = 4'b0100,
    DIR_N       = 4'b1000,
    DIR_INVALID = 4'b1111
  } dir_e;

endpackage

// File: rtl/ib_mem.sv
// Input-buffer storage: DEPTH x DATASIZE register array, one synchronous
// write port and one asynchronous read port. Contents are never reset.
module ib_mem
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH    = IB_DEPTH,
  parameter int unsigned WIDTH    = IB_WIDTH,
  parameter int unsigned DATASIZE = noc_pkg::DATASIZE
) (
  input  logic                ib_clk,
  input  logic                we,
  input  logic [WIDTH-1:0]    waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [WIDTH-1:0]    raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem [DEPTH];

  always_ff @(posedge ib_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ib_pressure_fifo.sv
// Per-port router input buffer: first-word-fall-through FIFO that publishes
// its occupancy as a pressure value for adaptive route selection.
module ib_pressure_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH    = IB_DEPTH,
  parameter int unsigned WIDTH    = IB_WIDTH,
  parameter int unsigned DATASIZE = noc_pkg::DATASIZE
) (
  input  logic                ib_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] link_data_in,
  input  logic                link_valid_in,
  output logic                link_ready_out,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  input  logic                rc_ready,
  output logic [WIDTH:0]      pressure_out,
  output logic                overflow_err
);

  localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH-1:0]    rd_ptr;
  logic [WIDTH:0]      count;
  logic [DATASIZE-1:0] rd_data;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Push is gated on the registered full flag, so a same-cycle pop never frees a slot early.
  assign push  = link_valid_in & ~full;
  assign pop   = ~empty & rc_ready;

  assign link_ready_out = ~full;
  assign valid_out      = ~empty;
  assign data_out       = empty ? '0 : rd_data;
  assign pressure_out   = count;

  ib_mem #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .DATASIZE (DATASIZE)
  ) u_mem (
    .ib_clk (ib_clk),
    .we     (push),
    .waddr  (wr_ptr),
    .wdata  (link_data_in),
    .raddr  (rd_ptr),
    .rdata  (rd_data)
  );

  always_ff @(posedge ib_clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (WIDTH+1)'(1);
        2'b01:   count <= count - (WIDTH+1)'(1);
        default: count <= count;
      endcase
      if (link_valid_in && full) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ib_pressure_fifo.sv
// Directed plus randomized bench for ib_pressure_fifo against a queue-based
// reference model of the buffer.
module tb_ib_pressure_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 40;

  logic          ib_clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] link_data_in;
  logic          link_valid_in;
  logic          link_ready_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          rc_ready;
  logic [3:0]    pressure_out;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q [$];
  bit            ovf_m       = 1'b0;
  bit            model_known = 1'b0;

  ib_pressure_fifo #(.DEPTH(8), .WIDTH(3), .DATASIZE(40)) dut (
    .ib_clk         (ib_clk),
    .rst_n          (rst_n),
    .link_data_in   (link_data_in),
    .link_valid_in  (link_valid_in),
    .link_ready_out (link_ready_out),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .rc_ready       (rc_ready),
    .pressure_out   (pressure_out),
    .overflow_err   (overflow_err)
  );

  always #5 ib_clk = ~ib_clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [DW-1:0] exp_data;
    int unsigned   n;
    n = model_q.size();
    exp_data = (n != 0) ? model_q[0] : '0;
    check("pressure",  DW'(pressure_out),   DW'(n));
    check("valid",     DW'(valid_out),      DW'(n != 0));
    check("ready",     DW'(link_ready_out), DW'(n < DEPTH));
    check("data",      data_out,            exp_data);
    check("overflow",  DW'(overflow_err),   DW'(ovf_m));
  endtask

  // Advance one clock edge, update the model from the rules, then compare.
  task automatic tick();
    bit full_m, push_m, pop_m;
    full_m = (model_q.size() == DEPTH);
    push_m = link_valid_in && !full_m;
    pop_m  = (model_q.size() != 0) && rc_ready;
    @(posedge ib_clk);
    #1;
    if (!rst_n) begin
      model_q.delete();
      ovf_m       = 1'b0;
      model_known = 1'b1;
    end else if (model_known) begin
      if (link_valid_in && full_m) ovf_m = 1'b1;
      if (pop_m)  void'(model_q.pop_front());
      if (push_m) model_q.push_back(link_data_in);
    end
    if (model_known) check_model();
  endtask

  function automatic logic [DW-1:0] pkt(input int unsigned i);
    return {4'(i), 4'h0, 8'(i - 1), 24'(i)};
  endfunction

  initial begin
    rst_n         = 1'b0;
    link_valid_in = 1'b1;
    link_data_in  = 40'h12_3456_789A;
    rc_ready      = 1'b0;
    tick();
    check("rst_pressure", DW'(pressure_out),   '0);
    check("rst_valid",    DW'(valid_out),      '0);
    check("rst_ready",    DW'(link_ready_out), DW'(1));
    check("rst_ovf",      DW'(overflow_err),   '0);
    check("rst_data",     data_out,            '0);

    // Fill to full with rc_ready low
    rst_n = 1'b1;
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      link_valid_in = 1'b1;
      link_data_in  = pkt(i);
      tick();
      check("fill_pressure", DW'(pressure_out), DW'(i));
    end
    link_valid_in = 1'b0;
    check("full_ready", DW'(link_ready_out), '0);
    check("full_head",  data_out, 40'h1_0_00_000001);

    // Push while full: dropped, sticky overflow
    link_valid_in = 1'b1;
    link_data_in  = 40'hF_F_FF_FFFFFF;
    tick();
    check("ovf_pressure", DW'(pressure_out), DW'(8));
    check("ovf_set",      DW'(overflow_err), DW'(1));
    link_valid_in = 1'b0;
    tick();
    check("ovf_sticky", DW'(overflow_err), DW'(1));

    // Drain in push order
    rc_ready = 1'b1;
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      check("drain_head", data_out, pkt(i));
      tick();
      check("drain_pressure", DW'(pressure_out), DW'(DEPTH - i));
    end
    check("drain_empty", DW'(valid_out), '0);
    tick();   // rc_ready while empty has no effect

    // Empty: simultaneous push and ready accepts push, no pop
    link_valid_in = 1'b1;
    link_data_in  = 40'h3_3_33_333333;
    tick();
    check("empty_pushpop", DW'(pressure_out), DW'(1));

    // Bring to 3 entries, then 20 cycles of simultaneous push/pop across the wrap
    rc_ready = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      link_data_in = {$urandom, $urandom};
      tick();
    end
    rc_ready = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      link_data_in = {$urandom, $urandom};
      tick();
      check("wrap_pressure", DW'(pressure_out), DW'(3));
    end

    // Mid-traffic reset at count=5
    rc_ready = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      link_data_in = {$urandom, $urandom};
      tick();
    end
    check("pre_rst_count", DW'(pressure_out), DW'(5));
    rst_n = 1'b0;
    tick();
    check("midrst_pressure", DW'(pressure_out), '0);
    check("midrst_valid",    DW'(valid_out),    '0);
    rst_n         = 1'b1;
    link_valid_in = 1'b1;
    link_data_in  = 40'hA_5_10_0000AB;
    tick();
    link_valid_in = 1'b0;
    check("single_data",     data_out,          40'hA_5_10_0000AB);
    check("single_pressure", DW'(pressure_out), DW'(1));

    // Randomized traffic with varying push/pop bias and rare resets
    for (int unsigned ph = 0; ph < 4; ph++) begin
      for (int unsigned c = 0; c < 150; c++) begin
        link_valid_in = ($urandom_range(0, 99) < (ph[0] ? 80 : 40));
        rc_ready      = ($urandom_range(0, 99) < (ph[1] ? 30 : 70));
        link_data_in  = {$urandom, $urandom};
        rst_n         = ($urandom_range(0, 99) >= 2);
        tick();
      end
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ib_pressure_fifo.md
Name: ib_pressure_fifo

Overview:
- Per-port input buffer of a 2D-mesh NoC router. It sits between the incoming link and the routing-computation stage.
- Accepts 40-bit packets from the upstream neighbour and presents them first-word-fall-through to the route-computation stage, which pops on its ready.
- Publishes its occupancy as the pressure value that neighbouring route-computation stages compare for adaptive N/W selection.

Parameters:
- DEPTH, 8, number of packet entries; must equal 2**WIDTH.
- WIDTH, 3, pointer width; the pressure/count width is WIDTH+1.
- DATASIZE, 40, packet width: src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0].

Ports:
- ib_clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the ib_clk rising edge.
- link_data_in  in  DATASIZE  packet from upstream link.
- link_valid_in  in  1  link_data_in valid this cycle.
- link_ready_out  out  1  buffer can accept a packet this cycle.
- data_out  out  DATASIZE  head-of-queue packet to route-computation stage.
- valid_out  out  1  head entry valid, i.e. buffer non-empty.
- rc_ready  in  1  route-computation stage consumes the head this cycle.
- pressure_out  out  WIDTH+1  registered occupancy, 0..DEPTH.
- overflow_err  out  1  sticky flag: a packet was presented while full.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - wr_ptr, rd_ptr and count are cleared to 0; overflow_err is cleared to 0.
  - Memory contents are not cleared.
  - Resulting outputs: link_ready_out=1, valid_out=0, pressure_out=0, data_out=0.
  - Reset asserted mid-traffic discards all queued packets; the next cycle behaves as empty.
- Output derivation:
  - full = (count==DEPTH); empty = (count==0).
  - link_ready_out = !full (combinational from count).
  - valid_out = !empty.
  - data_out = mem[rd_ptr] when !empty, else all-zero.
- Operations:
  - push = link_valid_in & !full. Write mem[wr_ptr] and increment wr_ptr modulo DEPTH (natural WIDTH-bit wrap).
  - pop = valid_out & rc_ready. Increment rd_ptr modulo DEPTH.
  - rc_ready while empty has no effect.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
  - Count never leaves 0..DEPTH.
- Full boundary:
  - push is blocked while full, even if a pop occurs in the same cycle; the slot reappears on the following cycle.
  - link_valid_in=1 while full: the packet is dropped and overflow_err is set to 1 on the next edge.
  - overflow_err holds until reset.
- Empty boundary:
  - A push into an empty buffer makes valid_out=1 on the next cycle.
  - First-word-fall-through latency: one cycle from accepted push to visibility on data_out.
  - Simultaneous link_valid_in and rc_ready while empty: the push is accepted and no pop occurs.
- Pressure:
  - pressure_out = count register, updated on the same edge as count.
  - It reflects occupancy after that cycle's push/pop.
- Ordering: strict FIFO, with no reordering and no modification of packet fields.

Decomposition:
- Shared package noc_pkg holds:
  - DATASIZE and the field bit positions: SRC_MSB/LSB 39/36, DST 35/32, TS 31/24, DATA 23/2, TYPE 1/0.
  - Direction encodings: N=4'b1000, W=4'b0100, LOCAL=4'b0000, INVALID=4'b1111.
  - Default DEPTH and WIDTH.
- One natural sub-module, ib_mem: a DEPTH x DATASIZE register array with one write port and one asynchronous read port.
- Pointer, count and flag logic stay in ib_pressure_fifo.

Test Plan:
- Reset with link_valid_in=1 held → after the edge: pressure_out=0, valid_out=0, link_ready_out=1, overflow_err=0, data_out=0.
- Push packets 40'h1_0_00_000001 through 40'h8_0_07_000008 on consecutive cycles with rc_ready=0:
  - pressure_out counts 1..8.
  - After the 8th push, link_ready_out=0 and data_out=40'h1_0_00_000001.
- When full, assert link_valid_in with 40'hF_F_FF_FFFFFF → no change to pressure_out (8) or contents; overflow_err=1 and stays 1.
- From full, rc_ready=1 for 8 cycles, no pushes → data_out sequence matches push order; pressure_out goes 7..0; valid_out=0 at the end.
- Pointer wrap: with the queue at 3 entries, do 20 cycles of simultaneous push and pop → pressure_out stays 3 throughout and popped data matches push order across the wrap.
- Mid-traffic reset at count=5 → the next cycle shows count 0 and valid_out=0. A subsequent single push of 40'hA_5_10_0000AB appears on data_out one cycle later with pressure_out=1.
